// File: rtl/memory_array.sv
// Single-port word array that zero-fills itself after reset, then serves
// registered reads. Define MEMORY_ARRAY_WRITE_FIRST_EN for write-first read/write collisions.
module memory_array #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              RST_,
    input  logic              CS,
    input  logic              W,
    input  logic              R,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [WIDTH-1:0]  D,
    output logic [WIDTH-1:0]  OUT,
    output logic              RVALID,
    output logic              READY,
    output logic              dbg_state
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic ST_INIT = 1'b0;
    localparam logic ST_IDLE = 1'b1;
    localparam logic [ADDR_W-1:0] CNT_LAST = '1;
    localparam logic [ADDR_W-1:0] CNT_ONE  = 1;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic              state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [WIDTH-1:0]  out_q, out_d;
    logic              rvalid_q, rvalid_d;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;

    // Access protocol: with READY=1, a CS&R edge makes OUT valid (RVALID=1) for
    // exactly the following cycle; CS&W commits D at that same edge. No stalls.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        out_d     = out_q;
        rvalid_d  = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = ADDR;
        wr_data   = D;
        case (state_q)
            ST_INIT: begin
                wr_en     = 1'b1;
                wr_addr   = clr_cnt_q;
                wr_data   = '0;
                clr_cnt_d = clr_cnt_q + CNT_ONE;
                if (clr_cnt_q == CNT_LAST) state_d = ST_IDLE;
            end
            default: begin
                wr_en = CS & W;
                if (CS & R) begin
                    rvalid_d = 1'b1;
`ifdef MEMORY_ARRAY_WRITE_FIRST_EN
                    out_d = W ? D : mem_q[ADDR];
`else
                    out_d = mem_q[ADDR];
`endif
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_) begin
            state_q   <= ST_INIT;
            clr_cnt_q <= '0;
            out_q     <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            out_q     <= out_d;
            rvalid_q  <= rvalid_d;
        end
    end

    // Contents are left untouched while reset is held; clearing restarts on release.
    always_ff @(posedge CLK) begin
        if (RST_ && wr_en) mem_q[wr_addr] <= wr_data;
    end

    assign OUT       = out_q;
    assign RVALID    = rvalid_q;
    assign READY     = (state_q == ST_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_memory_array.sv
// Directed bench for memory_array: clear sequence, vector table of accesses,
// and hand-written reset-abort sequences.
module tb_memory_array;

    logic       CLK = 1'b0;
    logic       RST_, CS, W, R;
    logic [3:0] ADDR;
    logic [7:0] D;
    logic [7:0] OUT;
    logic       RVALID, READY, dbg_state;

    int checks = 0;
    int errors = 0;

`ifdef MEMORY_ARRAY_WRITE_FIRST_EN
    localparam logic [7:0] RW_EXP = 8'h22;
`else
    localparam logic [7:0] RW_EXP = 8'h11;
`endif

    typedef struct {
        logic       cs;
        logic       w;
        logic       r;
        logic [3:0] addr;
        logic [7:0] d;
        logic [7:0] exp_out;
        logic       exp_rv;
    } vec_t;

    vec_t vecs[16];

    memory_array #(.WIDTH(8), .ADDR_W(4)) dut (
        .CLK(CLK), .RST_(RST_), .CS(CS), .W(W), .R(R), .ADDR(ADDR), .D(D),
        .OUT(OUT), .RVALID(RVALID), .READY(READY), .dbg_state(dbg_state)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic cs, input logic w, input logic r,
                         input logic [3:0] addr, input logic [7:0] d);
        CS = cs; W = w; R = r; ADDR = addr; D = d;
    endtask

    // Releases reset and walks the 16 clearing cycles, optionally hammering
    // accesses at an already-cleared address to prove they are ignored.
    task automatic run_init(input string tag);
        RST_ = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("%s_ready_low%0d", tag, i), READY, 1'b0);
            check($sformatf("%s_rvalid_low%0d", tag, i), RVALID, 1'b0);
            check($sformatf("%s_out_hold%0d", tag, i), OUT, 8'h00);
            if (i > 0) drive(1'b1, 1'b1, 1'b1, 4'd0, 8'hFF);
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        check({tag, "_ready_high"}, READY, 1'b1);
        check({tag, "_state_idle"}, dbg_state, 1'b1);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 4'd3, 8'hA5, 8'h00, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 4'd3, 8'h00, 8'hA5, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 4'd3, 8'h00, 8'hA5, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 4'd7, 8'h11, 8'hA5, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 4'd7, 8'h22, RW_EXP, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 4'd7, 8'h00, 8'h22, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 4'd2, 8'hFF, 8'h22, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 4'd2, 8'h00, 8'h00, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 4'd0, 8'h01, 8'h00, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 4'd1, 8'h02, 8'h00, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 4'd2, 8'h03, 8'h00, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 4'd0, 8'h00, 8'h01, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 4'd1, 8'h00, 8'h02, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 4'd2, 8'h00, 8'h03, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 4'd0, 8'h00, 8'h03, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 4'd1, 8'h00, 8'h03, 1'b0};

        // Clock/reset
        RST_ = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        step();
        step();
        check("rst_out", OUT, 8'h00);
        check("rst_rvalid", RVALID, 1'b0);
        check("rst_ready", READY, 1'b0);
        check("rst_state", dbg_state, 1'b0);

        run_init("init0");

        // Every word must read back zero after clearing.
        for (int a = 0; a < 16; a++) begin
            drive(1'b1, 1'b0, 1'b1, a[3:0], 8'h00);
            step();
            check($sformatf("clr_rd%0d_out", a), OUT, 8'h00);
            check($sformatf("clr_rd%0d_rv", a), RVALID, 1'b1);
        end
        drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        step();
        check("clr_rd_done_rv", RVALID, 1'b0);

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].cs, vecs[i].w, vecs[i].r, vecs[i].addr, vecs[i].d);
            step();
            check($sformatf("vec%0d_out", i), OUT, vecs[i].exp_out);
            check($sformatf("vec%0d_rv", i), RVALID, vecs[i].exp_rv);
        end

        // Reset during operation drops a pending RVALID.
        drive(1'b1, 1'b0, 1'b1, 4'd3, 8'h00);
        step();
        check("mid_rd_out", OUT, 8'hA5);
        check("mid_rd_rv", RVALID, 1'b1);
        RST_ = 1'b0;
        step();
        check("mid_rst_out", OUT, 8'h00);
        check("mid_rst_rv", RVALID, 1'b0);
        check("mid_rst_ready", READY, 1'b0);
        step();
        drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        run_init("init1");

        drive(1'b1, 1'b0, 1'b1, 4'd3, 8'h00);
        step();
        check("post_rst_a3", OUT, 8'h00);
        drive(1'b1, 1'b0, 1'b1, 4'd0, 8'h00);
        step();
        check("init_wr_blocked_a0", OUT, 8'h00);
        check("init_wr_blocked_rv", RVALID, 1'b1);

        // Abort clearing at counter 9, hold reset for two cycles.
        drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        RST_ = 1'b0;
        step();
        RST_ = 1'b1;
        for (int i = 0; i < 9; i++) step();
        check("abort_state_init", dbg_state, 1'b0);
        RST_ = 1'b0;
        step();
        step();
        check("abort_out", OUT, 8'h00);
        check("abort_rv", RVALID, 1'b0);
        run_init("init2");

        drive(1'b1, 1'b0, 1'b1, 4'd15, 8'h00);
        step();
        check("abort_rd15_out", OUT, 8'h00);
        check("abort_rd15_rv", RVALID, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        step();
        check("final_rv_low", RVALID, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_array.md
MEMORY_ARRAY -- requirements
Module: memory_array

Interface
REQ-001 Parameter WIDTH, default 8: data bits per word.
REQ-002 Parameter ADDR_W, default 4: address bits; DEPTH = 2**ADDR_W words, no out-of-range addresses exist.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST_  input  1  reset, synchronous and active-low.
REQ-005 CS  input  1  chip select; W and R are ignored when CS=0.
REQ-006 W  input  1  write enable.
REQ-007 R  input  1  read enable.
REQ-008 ADDR  input  ADDR_W  word address shared by read and write.
REQ-009 D  input  WIDTH  write data.
REQ-010 OUT  output  WIDTH  registered read data.
REQ-011 RVALID  output  1  high one cycle when OUT carries fresh read data.
REQ-012 READY  output  1  high when the array accepts accesses; low during clearing.

Function
REQ-013 Two states: INIT (clearing) and IDLE (operational).
REQ-014 INIT: one word written to 0 per cycle at clear counter 0..DEPTH-1, only when RST_=1; after word DEPTH-1 is cleared, next state IDLE.
REQ-015 INIT lasts exactly DEPTH cycles after RST_ deassertion; READY=0 throughout INIT, READY=1 from the first IDLE cycle.
REQ-016 In INIT, CS/W/R are ignored: no user write, RVALID stays 0, OUT holds.
REQ-017 IDLE write: CS=1 and W=1 at an edge stores D at ADDR at that edge.
REQ-018 IDLE read: CS=1 and R=1 at edge N loads OUT with word ADDR at edge N; RVALID=1 for the cycle after edge N (1-cycle latency), else 0.
REQ-019 OUT holds its last value when no read occurs; it is never undriven or X.
REQ-020 Back-to-back reads on consecutive cycles are supported at one result per cycle, RVALID remaining high.
REQ-021 Simultaneous R and W (CS=1, same ADDR) are both performed; returned data per REQ-026.
REQ-022 W=0 and R=0, or CS=0: memory, OUT unchanged; RVALID=0.

Reset
REQ-023 RST_=0 at an edge: state=INIT, clear counter=0, OUT=0, RVALID=0, READY=0.
REQ-024 Reset asserted mid-clear or mid-operation aborts the current access and restarts clearing from address 0 once RST_=1; a pending RVALID is dropped.
REQ-025 Memory contents are not guaranteed while RST_=0; every word reads 0 after INIT completes.

Configuration
REQ-026 Macro MEMORY_ARRAY_WRITE_FIRST_EN: defined -> simultaneous read/write to same ADDR returns new D on OUT (write-first); undefined -> returns the previously stored word (read-first); all other behaviour identical.

Verification
REQ-027 Release RST_ at cycle 0 -> READY=0 for cycles 0..15, READY=1 at cycle 16 (ADDR_W=4); read all 16 addresses -> each OUT=0x00.
REQ-028 IDLE: write 0xA5 to addr 3, then read addr 3 -> next cycle OUT=0xA5, RVALID=1 for one cycle, then RVALID=0 and OUT stays 0xA5.
REQ-029 Addr 7 holds 0x11; same cycle W=1, R=1, ADDR=7, D=0x22 -> OUT=0x11 without macro, 0x22 with MEMORY_ARRAY_WRITE_FIRST_EN; subsequent read of addr 7 -> 0x22 in both builds.
REQ-030 CS=0 with W=1, D=0xFF, ADDR=2, then CS=1 read addr 2 -> OUT=0x00 (write blocked).
REQ-031 Assert RST_=0 at clear counter 9, hold 2 cycles, release -> OUT=0, RVALID=0, READY low for exactly 16 further cycles; read during INIT -> RVALID stays 0.
REQ-032 Reads of addrs 0,1,2 on consecutive cycles after writes 0x01,0x02,0x03 -> OUT sequence 0x01,0x02,0x03 with RVALID high for 3 consecutive cycles.
